door_access_ctrl: RTL and testbench
===================================

# door_access_ctrl

Keypad entry and password verification controller for the door lock. It collects a fixed-length hex code from the keypad and compares it against the current stored password, which is the password generator's `newPass`. It drives `unlockDoor` and the time-limited `keyEnable` window that trigger a password refresh. It also counts failed attempts and raises an alarm lockout after too many failures.

## Interface
- `DIGITS`, 8: code length in hex digits; the code is `4*DIGITS` bits, so 8 digits gives 32 bits.
- `UNLOCK_CYCLES`, 16: number of cycles `unlockDoor` stays high after a match.
- `KEY_WINDOW`, 4: number of cycles `keyEnable` stays high. Legal only if `KEY_WINDOW + 1 < UNLOCK_CYCLES`.
- `MAX_FAIL`, 3: consecutive mismatches that trigger lockout; legal range 1..3.
- `LOCKOUT_CYCLES`, 64: duration of `alarm`.
- `ENTRY_TIMEOUT`, 32: idle cycles allowed between digits before the entry is abandoned.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `keyValid`  in  1  one-cycle strobe indicating that `keyDigit` holds a valid key press.
- `keyDigit`  in  4  hex key value, 0x0..0xF.
- `keyClear`  in  1  abandons the current entry.
- `storedPass`  in  `4*DIGITS`  current password (the generator's `newPass`).
- `unlockDoor`  out  1  door release.
- `keyEnable`  out  1  effective enable for the password generator.
- `alarm`  out  1  lockout indicator.
- `failCount`  out  2  consecutive mismatches since the last match or lockout.

## Operation
- States: IDLE, ENTRY, CHECK, UNLOCK, FAIL, LOCKOUT.
- Entry shift register: `entry <= {entry[4*DIGITS-5:0], keyDigit}`, so the first digit pressed ends up as the most significant nibble.
  - A digit counter counts 0..DIGITS.
- IDLE:
  - `keyValid` captures the digit, sets the count to 1, and moves to ENTRY.
  - `keyClear` is ignored in IDLE.
- ENTRY:
  - `keyValid` captures the digit and increments the count. When the count reaches DIGITS, the state moves to CHECK.
  - `keyClear` returns to IDLE with the entry and count zeroed. `failCount` is unchanged.
  - If `keyValid` and `keyClear` are high in the same cycle, `keyClear` wins.
  - If `ENTRY_TIMEOUT` consecutive cycles pass without `keyValid`, the state returns to IDLE and is treated exactly like `keyClear`.
- CHECK (exactly one cycle): `storedPass` is sampled in this cycle.
  - `entry == storedPass` moves to UNLOCK and sets `failCount` to 0.
  - On a mismatch, `failCount` is incremented. If the new value equals `MAX_FAIL`, the state moves to LOCKOUT; otherwise it moves to FAIL.
- FAIL (one cycle): moves to IDLE; the entry is zeroed.
- UNLOCK:
  - `unlockDoor` is high for all `UNLOCK_CYCLES` cycles in this state.
  - `keyEnable` rises on the second UNLOCK cycle and stays high for `KEY_WINDOW` cycles. It therefore both rises and falls while `unlockDoor` is high, which gives the generator exactly one qualifying rising edge per unlock.
  - At the end of the state, the entry is zeroed and the state moves to IDLE.
- LOCKOUT: `alarm` is high for `LOCKOUT_CYCLES` cycles, then `failCount` is set to 0 and the state moves to IDLE.
- `keyValid` and `keyClear` are ignored in CHECK, UNLOCK, FAIL and LOCKOUT; presses made in those states are lost.
- A password refreshed during UNLOCK applies to the next entry only.

## Timing
- Reset values: `unlockDoor`=0, `keyEnable`=0, `alarm`=0, `failCount`=0, state IDLE, entry and all counters 0.
- Reset asserted in any state returns the block to the reset values immediately, with no wait for a clock edge. No partial unlock or alarm pulse continues after reset releases.
- All outputs are registered.
- Latency, where edge N is the one that samples the final digit:
  - edge N: state becomes CHECK.
  - edge N+1: `unlockDoor` rises, or for a mismatch, FAIL/LOCKOUT is entered with `failCount` updated.
  - edge N+1 (LOCKOUT case): `alarm` rises on this same edge.
  - edge N+2: `keyEnable` rises.
  - edge N+2+KEY_WINDOW: `keyEnable` falls.
  - edge N+1+UNLOCK_CYCLES: `unlockDoor` falls and the state is IDLE.
- The timeout counter resets on every accepted `keyValid`. The return to IDLE happens on the edge that completes the `ENTRY_TIMEOUT`-th idle cycle.
- The earliest a new first digit is accepted is the first cycle spent in IDLE.

## Test plan
- Reset, then `storedPass`=0x1234ABCD; key 1,2,3,4,A,B,C,D on consecutive cycles → `unlockDoor` high for exactly 16 cycles starting 2 edges after the D press; `keyEnable` high for 4 cycles starting one edge after `unlockDoor` rises; `failCount`=0.
- Same password, enter 0x1234ABCE three times → `failCount` steps 1, 2; on the third mismatch `alarm` is high for 64 cycles and digits pressed during that time are ignored; after it ends, `failCount`=0 and a correct entry unlocks.
- Enter 5 digits, assert `keyClear` together with `keyValid` → IDLE, `failCount` unchanged; a following correct 8-digit entry unlocks.
- Enter 3 digits, then 32 idle cycles → back in IDLE with no failure counted; the next digit starts a fresh entry.
- Assert `reset` mid-UNLOCK (cycle 5) and separately mid-LOCKOUT (cycle 10) → all outputs 0 immediately, state IDLE, `failCount`=0.
- Two mismatches followed by a match → `failCount` returns to 0; a subsequent single mismatch gives `failCount`=1 and no alarm.

Source files
------------

// File: rtl/door_access_ctrl.sv
// Keypad code entry, password compare, unlock/keyEnable pulse generation and
// failed-attempt lockout for the door lock.
module door_access_ctrl #(
  parameter int DIGITS         = 8,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int KEY_WINDOW     = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int ENTRY_TIMEOUT  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  keyValid,
  input  logic [3:0]            keyDigit,
  input  logic                  keyClear,
  input  logic [4*DIGITS-1:0]   storedPass,
  output logic                  unlockDoor,
  output logic                  keyEnable,
  output logic                  alarm,
  output logic [1:0]            failCount
);

  localparam int PW   = 4*DIGITS;
  localparam int DCW  = $clog2(DIGITS+1);
  localparam int CMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                        ((UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT) :
                        ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT);
  localparam int CW   = $clog2(CMAX+1);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCK, FAIL, LOCKOUT} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   entry, entry_n;
  logic [DCW-1:0]  dcnt, dcnt_n;
  logic [CW-1:0]   cnt, cnt_n;    // entry idle timer / unlock / lockout timer
  logic [1:0]      fail_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      entry      <= '0;
      dcnt       <= '0;
      cnt        <= '0;
      failCount  <= '0;
      unlockDoor <= 1'b0;
      keyEnable  <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_n;
      entry      <= entry_n;
      dcnt       <= dcnt_n;
      cnt        <= cnt_n;
      failCount  <= fail_n;
      unlockDoor <= (state_n == UNLOCK);
      // cnt counts UNLOCK cycles from 0, so the window opens on the second one
      keyEnable  <= (state == UNLOCK) && (cnt < CW'(KEY_WINDOW));
      alarm      <= (state_n == LOCKOUT);
    end
  end

  always_comb begin
    state_n = state;
    entry_n = entry;
    dcnt_n  = dcnt;
    cnt_n   = cnt;
    fail_n  = failCount;
    case (state)
      IDLE: begin
        if (keyValid) begin
          entry_n = {entry[PW-5:0], keyDigit};
          dcnt_n  = DCW'(1);
          cnt_n   = '0;
          state_n = (DCW'(DIGITS) == DCW'(1)) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (keyClear || (!keyValid && cnt == CW'(ENTRY_TIMEOUT-1))) begin
          entry_n = '0;
          dcnt_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (keyValid) begin
          entry_n = {entry[PW-5:0], keyDigit};
          dcnt_n  = dcnt + DCW'(1);
          cnt_n   = '0;
          if (dcnt + DCW'(1) == DCW'(DIGITS)) state_n = CHECK;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CHECK: begin
        cnt_n  = '0;
        dcnt_n = '0;
        if (entry == storedPass) begin
          fail_n  = '0;
          state_n = UNLOCK;
        end else begin
          fail_n  = failCount + 2'd1;
          state_n = (fail_n == 2'(MAX_FAIL)) ? LOCKOUT : FAIL;
        end
      end
      FAIL: begin
        entry_n = '0;
        state_n = IDLE;
      end
      UNLOCK: begin
        if (cnt == CW'(UNLOCK_CYCLES-1)) begin
          entry_n = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LOCKOUT: begin
        if (cnt == CW'(LOCKOUT_CYCLES-1)) begin
          entry_n = '0;
          cnt_n   = '0;
          fail_n  = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Randomized bench for door_access_ctrl: a schedule-based reference model
// pushes per-cycle expected outputs; a negedge monitor pops and compares.
module tb_door_access_ctrl;
  localparam int DIGITS = 8, UC = 16, KW = 4, MAXF = 3, LC = 64, TO = 32;

  logic        clk, reset, keyValid, keyClear;
  logic [3:0]  keyDigit;
  logic [31:0] storedPass;
  logic        unlockDoor, keyEnable, alarm;
  logic [1:0]  failCount;

  door_access_ctrl #(.DIGITS(DIGITS), .UNLOCK_CYCLES(UC), .KEY_WINDOW(KW),
                     .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .keyValid(keyValid), .keyDigit(keyDigit),
    .keyClear(keyClear), .storedPass(storedPass), .unlockDoor(unlockDoor),
    .keyEnable(keyEnable), .alarm(alarm), .failCount(failCount));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic u, k, a; logic [1:0] f; int edge_no; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  // reference model: scheduled output windows per accepted code
  int t = 0, u_lo, u_hi, k_lo, k_hi, a_lo, a_hi, frst, ready, last, pend_edge;
  bit pend;
  int fc;
  logic [3:0] ent[$];

  task automatic model_reset();
    u_lo = 1; u_hi = 0; k_lo = 1; k_hi = 0; a_lo = 1; a_hi = 0;
    frst = -1; ready = 0; pend = 0; fc = 0; last = 0;
    ent.delete();
  endtask

  task automatic model_edge(input logic v, input logic [3:0] d, input logic c);
    logic [31:0] code;
    if (t == frst) fc = 0;
    if (pend && t == pend_edge) begin
      pend = 0;
      code = '0;
      foreach (ent[i]) code = (code << 4) | 32'(ent[i]);
      ent.delete();
      if (code == storedPass) begin
        fc = 0;
        u_lo = t; u_hi = t + UC - 1;
        k_lo = t + 1; k_hi = t + KW;
        ready = t + 1 + UC;
      end else begin
        fc++;
        if (fc == MAXF) begin
          a_lo = t; a_hi = t + LC - 1;
          frst = t + LC;
          ready = t + 1 + LC;
        end else begin
          ready = t + 2;
        end
      end
    end
    if (t >= ready && !pend) begin
      if (ent.size() > 0 && c) ent.delete();
      else if (v) begin
        ent.push_back(d);
        last = t;
        if (ent.size() == DIGITS) begin
          pend = 1; pend_edge = t + 1; ready = t + 2;
        end
      end else if (ent.size() > 0 && t - last == TO) ent.delete();
    end
  endtask

  // drive inputs for the next edge, let it happen, then set reset for after it
  task automatic step(input logic v, input logic [3:0] d, input logic c, input logic r);
    logic rst_cur;
    exp_t e;
    keyValid = v; keyDigit = d; keyClear = c;
    rst_cur = reset;
    @(posedge clk);
    t++;
    if (!rst_cur) model_edge(v, d, c);
    #1;
    reset = r;
    if (r) model_reset();
    e.u = (t >= u_lo && t <= u_hi);
    e.k = (t >= k_lo && t <= k_hi);
    e.a = (t >= a_lo && t <= a_hi);
    e.f = 2'(fc);
    e.edge_no = t;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [31:0] code);
    for (int i = 0; i < DIGITS; i++) step(1'b1, code[4*(DIGITS-1-i) +: 4], 1'b0, 1'b0);
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++)
      step(($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 9) == 0), 1'b0);
  endtask

  task automatic cmp(input string name, input int e_no, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, e_no, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("unlockDoor", e.edge_no, {1'b0, unlockDoor}, {1'b0, e.u});
      cmp("keyEnable",  e.edge_no, {1'b0, keyEnable},  {1'b0, e.k});
      cmp("alarm",      e.edge_no, {1'b0, alarm},      {1'b0, e.a});
      cmp("failCount",  e.edge_no, failCount, e.f);
    end
  end

  localparam logic [31:0] PASS = 32'h1234ABCD;
  localparam logic [31:0] BAD  = 32'h1234ABCE;

  initial begin
    reset = 1'b1; keyValid = 1'b0; keyDigit = '0; keyClear = 1'b0;
    storedPass = PASS;
    model_reset();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    // correct code
    enter(PASS); idle(20);
    // three mismatches -> lockout, presses ignored, then a correct code
    enter(BAD); idle(3);
    enter(BAD); idle(3);
    enter(BAD); noise(40); idle(30);
    enter(PASS); idle(20);
    // one mismatch, then partial entry aborted by keyClear+keyValid
    enter(BAD); idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, PASS[4*(7-i) +: 4], 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b0);
    idle(2);
    enter(PASS); idle(20);
    // abandon by timeout then fresh entry
    for (int i = 0; i < 3; i++) step(1'b1, 4'h9, 1'b0, 1'b0);
    idle(TO + 1);
    enter(PASS); idle(20);
    // reset in the 5th unlock cycle
    enter(PASS); idle(4);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    idle(20);
    // reset in the 10th lockout cycle
    enter(BAD); idle(3); enter(BAD); idle(3); enter(BAD); idle(9);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    idle(70);
    // two misses, a match, then a single miss
    enter(BAD); idle(3); enter(BAD); idle(3);
    enter(PASS); idle(20);
    enter(BAD); idle(5);
    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: begin enter(storedPass); idle($urandom_range(0, 20)); end
        1: begin enter($urandom); idle($urandom_range(0, 5)); end
        2: noise(20);
        3: idle($urandom_range(0, 40));
        4: storedPass = $urandom;
        default: begin step(1'b0, 4'h0, 1'b0, 1'b1); step(1'b0, 4'h0, 1'b0, 1'b0); end
      endcase
    end
    idle(2);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
